uart_rx_framer: RTL
===================

Name: uart_rx_framer

Overview:
- Sits directly downstream of the UART receiver; consumes its byte stream (tdata plus parity-error tuser).
- Groups received words into AXI-Stream packets with m_axis_tlast.
- A packet closes on one of three events: a delimiter word, reaching a maximum length, or the line going idle for a programmed time.
- The per-packet parity-error summary is reported on the last beat of the packet.

Parameters:
- WORD_SIZE, 8: data width; must match the receiver.
- DELIM_EN, 1: 1 = delimiter detection enabled.
- DELIM, 8'h0A: delimiter value; the delimiter word is included in the packet as its last beat.
- MAX_LEN, 256: maximum words per packet (≥1); the MAX_LEN-th word is forced last.
- IDLE_TIMEOUT, 1000: idle cycles after which an open packet closes; 0 disables the timeout.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_axis_tdata  in  WORD_SIZE  received word
- s_axis_tuser  in  1  parity error on this word
- s_axis_tvalid  in  1  upstream valid
- s_axis_tready  out  1  upstream ready
- m_axis_tdata  out  WORD_SIZE  packet data
- m_axis_tuser  out  1  packet had ≥1 parity error; meaningful only on the tlast beat, 0 otherwise
- m_axis_tlast  out  1  last word of packet
- m_axis_tvalid  out  1  downstream valid
- m_axis_tready  in  1  downstream ready

Behaviour:
- Reset (aresetn=0 at a rising edge):
  - All outputs and state go to 0: m_axis_tvalid/tdata/tuser/tlast=0, s_axis_tready=0 during reset.
  - Pending register empty; length and idle counters 0; error accumulator 0.
  - A reset mid-packet discards the pending word and any partial packet without emitting tlast.
- Storage:
  - Pending register P: one word, plus flags p_valid, p_final and accumulated error p_err.
  - Output register O drives m_axis directly.
  - O_free = !m_axis_tvalid || m_axis_tready.
- P states:
  - EMPTY: !p_valid.
  - OPEN: p_valid && !p_final; last-ness of the word is not yet known.
  - FINAL: p_valid && p_final.
- s_axis_tready = EMPTY || (OPEN && O_free). It is 0 in FINAL.
- Accept in EMPTY:
  - P <= word; len <= len+1; p_err <= p_err | tuser.
  - Final flag = (DELIM_EN && word==DELIM) || (len+1 == MAX_LEN).
- Accept in OPEN:
  - O <= P with tlast=0, tuser=0.
  - P <= new word; len, p_err and final flag are updated as for an accept in EMPTY.
- FINAL and O_free: O <= P with tlast=1, tuser=p_err; P goes to EMPTY; len <= 0; p_err <= 0. No accept in the same cycle.
- O with no new load: m_axis_tvalid clears on handshake; otherwise O holds stable while m_axis_tvalid && !m_axis_tready (AXI-Stream stability rule).
- Idle counter:
  - Counts only while OPEN && !s_axis_tvalid; cleared in every other cycle.
  - When it reaches IDLE_TIMEOUT (and IDLE_TIMEOUT≠0), p_final <= 1 and the counter clears.
  - If s_axis_tvalid is high in that same cycle, the arrival wins and no timeout occurs.
- Latency: a word accepted at edge t that is final (delimiter or max-length) appears on m_axis after edge t+1, if O is free.
- Non-final words are emitted only when the next word is accepted.
- Widths:
  - len: $clog2(MAX_LEN+1) bits.
  - Idle counter: $clog2(IDLE_TIMEOUT+1) bits.
  - Neither counter wraps: len resets at packet close, the idle counter saturates at its clear.
- Single-word packets (e.g., a lone delimiter, or MAX_LEN=1) close immediately.
- Back-to-back packets: there is a minimum one-cycle gap (FINAL state) between the delimiter accept and the next accept.

Test Plan:
- Send 0x41, 0x42, 0x0A back-to-back with m_axis_tready=1 → m_axis beats 41/last0, 42/last0, 0A/last1, tuser=0 on all; s_axis_tready low exactly one cycle after the 0x0A accept.
- Send 0x31, 0x32, then idle with IDLE_TIMEOUT=1000 → 0x31 emitted when 0x32 arrives; 0x32 emitted with tlast=1 after 1000 idle cycles (not at 999).
- MAX_LEN=4, DELIM_EN=0, send 6 words 0x01–0x06 → tlast on 0x04; 0x05 and 0x06 start the second packet; len restarts at 1.
- Parity error: send 0x10 (tuser=1), 0x11, 0x0A → tuser=0 on the 0x10 and 0x11 beats, tuser=1 on the 0x0A last beat; the next packet's tuser=0.
- Hold m_axis_tready=0 for 20 cycles mid-packet while sending 5 words → s_axis_tready deasserts; m_axis data stays stable; no word is lost or duplicated; order is preserved after release.
- Assert aresetn=0 for 1 cycle after 2 words of an open packet → m_axis_tvalid=0 the next cycle; the next packet 0x55, 0x0A emerges alone with tlast on 0x0A.

Source files
------------

// File: rtl/uart_rx_framer.sv
// Packetizes the UART receiver's word stream into AXI-Stream packets.
// A packet closes on a delimiter word, on reaching MAX_LEN words, or after an idle timeout.
module uart_rx_framer #(
  parameter int                   WORD_SIZE    = 8,
  parameter bit                   DELIM_EN     = 1'b1,
  parameter logic [WORD_SIZE-1:0] DELIM        = 'h0A,
  parameter int                   MAX_LEN      = 256,
  parameter int                   IDLE_TIMEOUT = 1000
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [WORD_SIZE-1:0] s_axis_tdata,
  input  logic                 s_axis_tuser,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [WORD_SIZE-1:0] m_axis_tdata,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int IDLE_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(IDLE_TIMEOUT);

  // The pending word waits here until we know whether it ends its packet.
  typedef enum logic [1:0] {
    P_EMPTY = 2'd0,
    P_OPEN  = 2'd1,
    P_FINAL = 2'd2
  } p_state_t;

  p_state_t             p_state_reg, p_state_next;
  logic [WORD_SIZE-1:0] p_data_reg, p_data_next;
  logic                 p_err_reg, p_err_next;
  logic [LEN_W-1:0]     len_reg, len_next;
  logic [IDLE_W-1:0]    idle_reg, idle_next;

  logic [WORD_SIZE-1:0] o_data_reg, o_data_next;
  logic                 o_user_reg, o_user_next;
  logic                 o_last_reg, o_last_next;
  logic                 o_valid_reg, o_valid_next;

  logic                 o_free;
  logic                 accept;
  logic                 word_final;
  logic [LEN_W-1:0]     len_inc;
  logic [IDLE_W-1:0]    idle_inc;

  assign o_free        = !o_valid_reg || m_axis_tready;
  assign s_axis_tready = aresetn &&
                         ((p_state_reg == P_EMPTY) || ((p_state_reg == P_OPEN) && o_free));
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign len_inc       = len_reg + 1'b1;
  assign idle_inc      = idle_reg + 1'b1;
  assign word_final    = (DELIM_EN && (s_axis_tdata == DELIM)) || (len_inc == LEN_MAX);

  assign m_axis_tdata  = o_data_reg;
  assign m_axis_tuser  = o_user_reg;
  assign m_axis_tlast  = o_last_reg;
  assign m_axis_tvalid = o_valid_reg;

  always_comb begin
    p_state_next = p_state_reg;
    p_data_next  = p_data_reg;
    p_err_next   = p_err_reg;
    len_next     = len_reg;
    idle_next    = '0;
    o_data_next  = o_data_reg;
    o_user_next  = o_user_reg;
    o_last_next  = o_last_reg;
    o_valid_next = o_valid_reg;

    // A completed handshake empties O unless something is loaded below.
    if (m_axis_tready) begin
      o_valid_next = 1'b0;
      o_user_next  = 1'b0;
      o_last_next  = 1'b0;
    end

    case (p_state_reg)
      P_EMPTY: begin
        if (accept) begin
          p_data_next  = s_axis_tdata;
          len_next     = len_inc;
          p_err_next   = p_err_reg | s_axis_tuser;
          p_state_next = word_final ? P_FINAL : P_OPEN;
        end
      end
      P_OPEN: begin
        if (accept) begin
          // A new arrival proves the pending word was not the last one.
          o_data_next  = p_data_reg;
          o_user_next  = 1'b0;
          o_last_next  = 1'b0;
          o_valid_next = 1'b1;
          p_data_next  = s_axis_tdata;
          len_next     = len_inc;
          p_err_next   = p_err_reg | s_axis_tuser;
          p_state_next = word_final ? P_FINAL : P_OPEN;
        end else if (!s_axis_tvalid && (IDLE_TIMEOUT != 0)) begin
          if (idle_inc == IDLE_LIM) begin
            p_state_next = P_FINAL;
          end else begin
            idle_next = idle_inc;
          end
        end
      end
      P_FINAL: begin
        if (o_free) begin
          o_data_next  = p_data_reg;
          o_user_next  = p_err_reg;
          o_last_next  = 1'b1;
          o_valid_next = 1'b1;
          p_state_next = P_EMPTY;
          len_next     = '0;
          p_err_next   = 1'b0;
        end
      end
      default: begin
        p_state_next = P_EMPTY;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      p_state_reg <= P_EMPTY;
      p_data_reg  <= '0;
      p_err_reg   <= 1'b0;
      len_reg     <= '0;
      idle_reg    <= '0;
      o_data_reg  <= '0;
      o_user_reg  <= 1'b0;
      o_last_reg  <= 1'b0;
      o_valid_reg <= 1'b0;
    end else begin
      p_state_reg <= p_state_next;
      p_data_reg  <= p_data_next;
      p_err_reg   <= p_err_next;
      len_reg     <= len_next;
      idle_reg    <= idle_next;
      o_data_reg  <= o_data_next;
      o_user_reg  <= o_user_next;
      o_last_reg  <= o_last_next;
      o_valid_reg <= o_valid_next;
    end
  end

endmodule
